// File: rtl/uart_irq_ctrl.sv
// UART status interrupt controller: captures status bits, latches error events as sticky
// pending flags, masks them with a CPU-written enable and serves read-to-clear status reads.
module uart_irq_ctrl #(
    parameter int NBITS = 7,
    parameter int NEVT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] status_in,
    input  logic             ie_wr,
    input  logic [NBITS-1:0] ie_wdata,
    output logic [NBITS-1:0] ie,
    input  logic             rd_req,
    output logic [NBITS:0]   rd_data,
    output logic             rd_valid,
    output logic             irq
);

    typedef enum logic [1:0] {IDLE, ASSERTED, HOLDOFF} state_t;

    // Low NEVT bits are sticky events, the rest simply follow the captured level.
    localparam logic [NBITS-1:0] EVT_MASK = NBITS'((1 << NEVT) - 1);

    logic [NBITS-1:0] s1;
    logic [NBITS-1:0] s2;
    logic [NBITS-1:0] rise;
    logic [NBITS-1:0] pending;
    logic [NBITS-1:0] pending_nxt;
    logic             hit;
    state_t           state;
    state_t           state_nxt;

    assign rise = s1 & ~s2;
    assign hit  = |(pending & ie);

    // Rise is OR-ed in after the clear so a same-cycle event survives the read.
    assign pending_nxt = (((pending & ~{NBITS{rd_req}}) | rise) & EVT_MASK)
                       | (s1 & ~EVT_MASK);

    // Capture stage and pending/mask/read registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            pending  <= '0;
            ie       <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            s1       <= status_in;
            s2       <= s1;
            pending  <= pending_nxt;
            rd_valid <= rd_req;
            if (ie_wr) begin
                ie <= ie_wdata;
            end
            if (rd_req) begin
                rd_data <= {irq, pending};
            end
        end
    end

    // Interrupt FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // HOLDOFF forces at least two low cycles on irq after every serviced read.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_nxt = ASSERTED;
                end
            end
            ASSERTED: begin
                if (rd_req) begin
                    state_nxt = HOLDOFF;
                end else if (!hit) begin
                    state_nxt = IDLE;
                end
            end
            HOLDOFF: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        irq = (state == ASSERTED);
    end

endmodule
